bit_stream_serializer: RTL

- Upstream feeder for the serial pattern-detector stage: accepts parallel words on a valid/ready interface and emits them one bit per clock as a 1-bit serial stream.
- A one-entry holding buffer lets back-to-back words stream with no idle bit between frames.
- `ser_dout` drives the detector's serial data input directly.
- `ser_valid`, `busy` and `word_done` go to control and monitoring logic.

---
 rtl/ser_pkg.sv | 30 +++
 rtl/ser_hold_buf.sv | 47 ++++
 rtl/bit_stream_serializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and helpers for the bit-stream serializer.
// Compile-time option: SER_PARITY_EN appends an even-parity bit to every frame.
// Holds the FSM state type, frame-length helper and parity helper.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Widest word the block is built for; helper inputs are sized to this.
  localparam int MAX_WIDTH = 32;

`ifdef SER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial frame length for a given word width (data bits plus optional parity).
  function automatic int frame_len(input int width);
    return width + (PARITY_EN ? 1 : 0);
  endfunction

  // Even parity over a zero-extended data word.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register with full flag.
// Latency: written word visible on rd_data the cycle after wr_en.
// Backpressure: owner must not write while full; pop empties it.
module ser_hold_buf
  import ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] rd_data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: a write fills the entry, a pop empties it.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_en) begin
      full_d = 1'b1;
      data_d = wr_data;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  // Entry register; reset drops any held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full    = full_q;
  assign rd_data = data_q;

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter, one bit per clock, with a one-word holding buffer.
// Latency: word accepted at edge N drives its first bit in cycle N+1; frames run back-to-back.
// Backpressure: s_ready = holding buffer empty (registered); SER_PARITY_EN adds a parity bit.
module bit_stream_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ser_dout,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic                   ser_dout_q, ser_dout_d;
  logic                   ser_valid_q, ser_valid_d;

  logic                   xfer;
  logic                   hold_full;
  logic [WIDTH-1:0]       hold_data;
  logic                   hold_wr;
  logic                   hold_pop;
  logic                   load_en;
  logic [WIDTH-1:0]       load_word;
  logic [FRAME_LEN-1:0]   frame;

  // Lay a word out in transmit order: frame[FRAME_LEN-1] goes on the line first.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [WIDTH-1:0] w);
    logic [FRAME_LEN-1:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f[FRAME_LEN-1-i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
    end
`ifdef SER_PARITY_EN
    f[0] = even_parity(MAX_WIDTH'(w));
`endif
    return f;
  endfunction

  ser_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (hold_wr),
    .wr_data (s_data),
    .pop     (hold_pop),
    .full    (hold_full),
    .rd_data (hold_data)
  );

  // Ready depends only on registered state; held low while reset is asserted.
  assign s_ready = !hold_full && !reset;
  assign xfer    = s_valid && s_ready;

  // Next-state: shift out the current frame, chain the next word in on the last bit.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ser_dout_d  = ser_dout_q;
    hold_wr     = 1'b0;
    hold_pop    = 1'b0;
    load_en     = 1'b0;
    load_word   = s_data;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          load_en = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_q != '0) begin
          ser_dout_d = shift_q[FRAME_LEN-1];
          shift_d    = shift_q << 1;
          bit_cnt_d  = bit_cnt_q - CNT_W'(1);
          hold_wr    = xfer;
        end else if (hold_full) begin
          // Held word takes priority; s_ready is low this cycle so no new transfer.
          load_en   = 1'b1;
          load_word = hold_data;
          hold_pop  = 1'b1;
        end else if (xfer) begin
          load_en = 1'b1;
        end else begin
          state_d    = IDLE;
          ser_dout_d = IDLE_LEVEL;
        end
      end
      default: begin
        state_d    = IDLE;
        ser_dout_d = IDLE_LEVEL;
      end
    endcase

    frame = build_frame(load_word);
    if (load_en) begin
      state_d    = SHIFT;
      ser_dout_d = frame[FRAME_LEN-1];
      shift_d    = frame << 1;
      bit_cnt_d  = CNT_W'(FRAME_LEN - 1);
    end

    ser_valid_d = (state_d == SHIFT);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ser_dout_q  <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ser_dout_q  <= ser_dout_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  assign ser_dout  = ser_dout_q;
  assign ser_valid = ser_valid_q;
  assign busy      = (state_q == SHIFT) || hold_full;
  assign word_done = (state_q == SHIFT) && (bit_cnt_q == '0);

endmodule
